fifo_cmd_ctrl: RTL

//  Command-driven controller between the UART front end and the SD card side.

---
 rtl/fifo_cmd_ctrl_if.sv | 37 +++
 rtl/fifo_cmd_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fifo_cmd_ctrl_if.sv
// fifo_cmd_ctrl_if
//   Groups the controller's front-end, UART TX and SD-side signals.
//   Modports:
//     slave  - the controller (fifo_cmd_ctrl): consumes cmd/rx/ready/ack
//              inputs and drives tx/SD requests and status.
//     master - the environment (front end / UART / SD side).
//   Parameters: DW (data width), CNT_W (word count width).
interface fifo_cmd_ctrl_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic [7:0]       cmd;
    logic [CNT_W-1:0] rx_cnt;
    logic [DW-1:0]    rx_data;
    logic             rx_vld;
    logic             tx_rdy;
    logic [DW-1:0]    tx_data;
    logic             tx_vld;
    logic             sd_init;
    logic             init_ok;
    logic             sd_ren;
    logic             sd_read_ok;
    logic             fe_done;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  cmd, rx_cnt, rx_data, rx_vld, tx_rdy, init_ok, sd_read_ok, fe_done,
        output tx_data, tx_vld, sd_init, sd_ren, busy, done, err
    );

    modport master (
        output cmd, rx_cnt, rx_data, rx_vld, tx_rdy, init_ok, sd_read_ok, fe_done,
        input  tx_data, tx_vld, sd_init, sd_ren, busy, done, err
    );
endinterface

// File: rtl/fifo_cmd_ctrl.sv
// fifo_cmd_ctrl
//   Command-driven controller between the UART front end and the SD side.
//   LOAD   : store rx_cnt words in a DEPTH-entry FIFO, then echo them to TX.
//   SDINIT : swallow rx_cnt argument words, then hold sd_init until init_ok.
//   SDREAD : hold sd_ren until sd_read_ok.
//   Overflowing pushes are dropped and flagged on err (sticky until DONE exits).
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fifo_cmd_ctrl_if.slave (cmd/rx_cnt/rx_data/rx_vld in,
//                tx_rdy in, tx_data/tx_vld out, sd_init/init_ok,
//                sd_ren/sd_read_ok, fe_done in, busy/done/err out)
// Optional feature
//   FIFO_CMD_TIMEOUT_EN : watchdog of TO_CYC cycles in SD_INIT/SD_READ;
//                         on expiry the request drops, err sets, go DONE.
module fifo_cmd_ctrl #(
    parameter int         DW         = 8,
    parameter int         DEPTH      = 16,
    parameter int         CNT_W      = 16,
    parameter logic [7:0] CMD_LOAD   = 8'h01,
    parameter logic [7:0] CMD_SDINIT = 8'h02,
    parameter logic [7:0] CMD_SDREAD = 8'h03,
    parameter int         TO_CYC     = 1000000
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_cmd_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_SD_ARG, S_SD_INIT, S_SD_READ, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      occ;
    logic             empty, full;
    logic             rx_take, push, pop, tmo;
    logic [DW-1:0]    tx_data;
    logic             tx_vld, sd_init, sd_ren, err;

    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    // A word is counted only while words are still owed; cnt never underflows.
    assign rx_take = bus.rx_vld && (cnt != '0);
    assign push    = (state == S_LOAD) && rx_take && !full;
    // The !tx_vld term spaces strobes so tx_rdy is re-sampled after each word.
    assign pop     = (state == S_DRAIN) && bus.tx_rdy && !empty && !tx_vld;

`ifdef FIFO_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt;

    // Counts cycles spent in the current SD wait state; restarts on any
    // state change so each wait gets the full budget.
    always_ff @(posedge clk) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state_nxt != state)
            to_cnt <= '0;
        else if (state == S_SD_INIT || state == S_SD_READ)
            to_cnt <= to_cnt + TW'(1);
    end

    assign tmo = (state == S_SD_INIT || state == S_SD_READ) &&
                 (to_cnt == TW'(TO_CYC - 1));
`else
    logic unused_to;
    assign unused_to = ^TO_CYC;
    assign tmo       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.cmd == CMD_LOAD)        state_nxt = S_LOAD;
                else if (bus.cmd == CMD_SDINIT) state_nxt = S_SD_ARG;
                else if (bus.cmd == CMD_SDREAD) state_nxt = S_SD_READ;
            end
            S_LOAD:    if (cnt == '0) state_nxt = S_DRAIN;
            S_DRAIN:   if (empty && !tx_vld) state_nxt = S_DONE;
            S_SD_ARG:  if (cnt == '0) state_nxt = S_SD_INIT;
            S_SD_INIT: if (bus.init_ok || tmo) state_nxt = S_DONE;
            S_SD_READ: if (bus.sd_read_ok || tmo) state_nxt = S_DONE;
            S_DONE:    if (bus.fe_done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage carries no reset; pointers/occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            tx_data <= '0;
            tx_vld  <= 1'b0;
            sd_init <= 1'b0;
            sd_ren  <= 1'b0;
            err     <= 1'b0;
        end else begin
            tx_vld <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (push)     occ <= occ + (PW+1)'(1);
            else if (pop) occ <= occ - (PW+1)'(1);

            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LOAD || state_nxt == S_SD_ARG) cnt <= bus.rx_cnt;
                    if (state_nxt == S_SD_READ) sd_ren <= 1'b1;
                end
                S_LOAD: begin
                    if (rx_take) cnt <= cnt - CNT_W'(1);
                    if (rx_take && full) err <= 1'b1;
                end
                S_SD_ARG: begin
                    if (rx_take) cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) sd_init <= 1'b1;
                end
                S_SD_INIT: begin
                    if (state_nxt == S_DONE) sd_init <= 1'b0;
                    if (tmo && !bus.init_ok) err <= 1'b1;
                end
                S_SD_READ: begin
                    if (state_nxt == S_DONE) sd_ren <= 1'b0;
                    if (tmo && !bus.sd_read_ok) err <= 1'b1;
                end
                S_DONE: if (bus.fe_done) err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.tx_data = tx_data;
    assign bus.tx_vld  = tx_vld;
    assign bus.sd_init = sd_init;
    assign bus.sd_ren  = sd_ren;
    assign bus.err     = err;
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
endmodule
